// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731 I2C configuration writer.
// Latency: n/a (package). Backpressure: n/a.
// Frame is START, three ACKed bytes and STOP; quarter counts cover that frame.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [6:0] WM8731_ADDR        = 7'h1A;
    localparam int         BYTES_PER_FRAME    = 3;
    localparam int         QUARTERS_PER_FRAME = 116;

endpackage

// File: rtl/scl_tick_gen.sv
// Quarter-period strobe for the SCL waveform: qtick once every CLK_DIV enabled cycles.
// Latency: first qtick CLK_DIV cycles after en rises. Backpressure: none, en gates it.
// Counter is parked at 0 while disabled so every frame starts phase-aligned.
module scl_tick_gen #(
    parameter int CLK_DIV = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic qtick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_codec_writer.sv
// Write-only I2C master sending {addr+W, data[15:8], data[7:0]} to the WM8731.
// Latency: done 116*CLK_DIV+1 cycles after an ACKed start; shorter on NACK.
// Backpressure: start is only taken in IDLE; starts while busy or in DONE are dropped.
module i2c_codec_writer
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 31,
    parameter logic [6:0] DEV_ADDR = WM8731_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_out,
    output logic        ts,
    input  logic        sda_in
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_FRAME - 1);

    state_t      state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  shift;
    logic [15:0] data_q;
    logic        qtick;
    logic        tick_en;

    assign tick_en = (state != ST_IDLE) && (state != ST_DONE);

    scl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .qtick (qtick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            q        <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shift    <= 8'd0;
            data_q   <= 16'd0;
            scl      <= 1'b1;
            ts       <= 1'b1;
            sda_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            sda_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    q    <= 2'd0;
                    done <= 1'b0;
                    if (start) begin
                        data_q   <= data;
                        ack_err  <= 1'b0;
                        byte_idx <= 2'd0;
                        shift    <= {DEV_ADDR, 1'b0};
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl <= 1'b1; ts <= 1'b1; end
                        2'd1: ts <= 1'b0;
                        2'd2: ;
                        2'd3: begin
                            scl     <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= ST_BIT;
                        end
                    endcase
                end
                ST_BIT: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl <= 1'b0; ts <= shift[7]; end
                        2'd1: scl <= 1'b1;
                        2'd2: ;
                        2'd3: begin
                            scl   <= 1'b0;
                            shift <= {shift[6:0], 1'b0};
                            if (bit_cnt == 3'd0) state <= ST_ACK;
                            else                 bit_cnt <= bit_cnt - 3'd1;
                        end
                    endcase
                end
                ST_ACK: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: ts <= 1'b1;
                        2'd1: scl <= 1'b1;
                        2'd2: if (sda_in) ack_err <= 1'b1;
                        2'd3: begin
                            scl <= 1'b0;
                            // A NACK anywhere aborts the rest of the frame.
                            if (!ack_err && byte_idx < LAST_BYTE) begin
                                byte_idx <= byte_idx + 2'd1;
                                shift    <= (byte_idx == 2'd0) ? data_q[15:8] : data_q[7:0];
                                bit_cnt  <= 3'd7;
                                state    <= ST_BIT;
                            end else begin
                                state <= ST_STOP;
                            end
                        end
                    endcase
                end
                ST_STOP: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl <= 1'b0; ts <= 1'b0; end
                        2'd1: scl <= 1'b1;
                        2'd2: ts <= 1'b1;
                        2'd3: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_codec_writer.md
Name: i2c_codec_writer

Overview:
- I2C write-only master that configures the WM8731 audio codec over FPGA_I2C_SCLK/FPGA_I2C_SDAT.
- Replaces the manual ISSP source drive of the I2C pins. The top level instantiates it and drives the pins directly.
- One transaction is a 3-byte write: device address+W, then data[15:8], then data[7:0]. The two data bytes carry the WM8731 7-bit register address and 9-bit value.
- Reports completion and NACK errors to the sequencer upstream.

Parameters:
- CLK_DIV, 31, clk cycles per SCL quarter-period. 12.288 MHz clk gives ~99 kHz SCL. Legal minimum is 2.
- DEV_ADDR, 7'h1A, 7-bit slave address (WM8731, CSB low).

Ports:
- clk  in  1  system clock (the audio PLL output that also drives AUD_XCK)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request. Sampled only in IDLE.
- data  in  16  {reg_addr[6:0], value[8:0]}. Latched on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at transaction end, with or without error.
- ack_err  out  1  set when any ACK slot samples SDA=1. Held until the next accepted start.
- scl  out  1  SCL, push-pull. Wired to FPGA_I2C_SCLK.
- sda_out  out  1  SDA drive value. Always 0 (open-drain emulation).
- ts  out  1  1 = release SDA (bus reads high), 0 = drive sda_out. Top level does ts ? Z : sda_out.
- sda_in  in  1  SDA pin readback.

Behaviour:
- Reset values: scl=1, ts=1, sda_out=0, busy=0, done=0, ack_err=0, state IDLE. All outputs are registered.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and emits qtick when it wraps.
  - Counter is held at 0 in IDLE, so the first qtick comes exactly CLK_DIV cycles after busy rises.
  - Each state advances one quarter (q0..q3) per qtick.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE:
  - start=1 latches data, clears ack_err, sets byte_idx=0, loads the shift register with {DEV_ADDR,1'b0}, sets busy=1.
  - Next state is START.
- START:
  - q0: scl=1, ts=1.
  - q1: ts=0 (SDA falls while SCL high).
  - q2: hold.
  - q3: scl=0. Then go to BIT with bit_cnt=7.
- BIT:
  - q0: scl=0, ts = shift[7] (1 releases, 0 drives low).
  - q1: scl=1.
  - q2: hold.
  - q3: scl=0, shift left.
  - bit_cnt decrements each bit. After bit_cnt=0, go to ACK.
- ACK:
  - q0: ts=1.
  - q1: scl=1.
  - q2: sample sda_in. 1 sets ack_err.
  - q3: scl=0.
  - Exit: if ack_err, go to STOP. Else if byte_idx<2, increment byte_idx, load the next data byte, go to BIT. Else go to STOP.
- STOP:
  - q0: scl=0, ts=0.
  - q1: scl=1.
  - q2: ts=1 (SDA rises while SCL high).
  - q3: hold. Then go to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, then IDLE.
  - A start asserted in the DONE cycle is ignored.
- Latency, ACKed frame: 4 + 27×4 + 4 = 116 quarters. done fires 116×CLK_DIV+1 cycles after the start cycle.
- NACK on byte k (0..2): frame ends after that ACK slot plus STOP. No further data bits are sent.
- start while busy is ignored. Changes to data while busy have no effect.
- SDA changes only while scl=0, except the START and STOP edges.
- Reset mid-frame: all outputs return to reset values on the next clock. No STOP is generated. A bus glitch is accepted.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - WM8731_ADDR = 7'h1A;
  - BYTES_PER_FRAME = 3;
  - QUARTERS_PER_FRAME = 116.
- Sub-module scl_tick_gen (parameter CLK_DIV; ports clk, reset, en, qtick) holds the quarter divider.
- The FSM, shift register and counters stay in i2c_codec_writer.

Test Plan (CLK_DIV=2; bench slave model decodes the SCL/SDA bus and drives ACK via sda_in):
1. Reset held 3 cycles -> scl=1, ts=1, sda_out=0, busy=0, done=0, ack_err=0. Outputs stay there with no start.
2. start with data=16'h1E00, slave ACKs all bytes -> model captures bytes 0x34, 0x1E, 0x00 and sees valid START/STOP. done pulses once at cycle 233 after start. ack_err=0, busy=0 on that cycle.
3. start with data=16'h0C00, slave NACKs the address byte -> ack_err=1. STOP follows the first ACK slot and no data bits appear. done at cycle (4+36+4)×2+1 = 89.
4. Second start pulse and data=16'hFFFF applied mid-transfer of 16'h0E4A -> bus shows only 0x34, 0x0E, 0x4A. Exactly one done.
5. Reset asserted mid-transfer of 16'h1000 -> next cycle scl=1, ts=1, busy=0. A following start of 16'h1201 completes normally.
6. start in the DONE cycle, then again one cycle later -> first is ignored, second is accepted (busy rises the next cycle).
